hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//   Stall and forwarding control for the 5-stage pipeline. Consumes the decoder's per-instruction
//   timing codes (rs/rt use stage, result-ready stage) for the instruction in D, and keeps its own
//   E/M/W shadow records of destination register and ready stage. Produces the D-stage stall
//   and the forwarding-mux selects for D, E and M consumers.
// PARAMETERS
//   NONE_T  4'hF  code meaning "operand not used" / "no register result"
// PORTS
//   clk          in   1  clock
//   reset        in   1  synchronous, active-high reset
//   rs_D         in   5  rs field of instruction in D
//   rt_D         in   5  rt field of instruction in D
//   tuse_rs_D    in   4  stage that first uses rs (0=D,1=E,2=M,3=W; NONE_T=unused)
//   tuse_rt_D    in   4  same for rt
//   a3_D         in   5  destination register of instruction in D (already rd/rt/31 selected)
//   tnew_D       in   4  stage where result exists (0..3; NONE_T=no result)
//   regwe_D      in   1  instruction in D writes the register file
//   stall        out  1  hold PC and F/D register; insert bubble into D/E
//   fwd_rs_D     out  2  D-stage rs source: 00 GRF, 01 E, 10 M, 11 W
//   fwd_rt_D     out  2  D-stage rt source, same encoding
//   fwd_rs_E     out  2  E-stage rs source: 00 pipeline reg, 10 M, 11 W
//   fwd_rt_E     out  2  E-stage rt source, same encoding as fwd_rs_E
//   fwd_rt_M     out  2  M-stage rt (store data) source: 00 pipeline reg, 11 W
// BEHAVIOUR
//   - Records: E,M,W each hold {valid, a3[4:0], t[3:0]}; E also rs,rt; M also rt.
//     Record valid only if regwe && a3!=0 && t!=NONE_T. Stage index: D=0,E=1,M=2,W=3.
//   - Every posedge clk (reset=0): W<=M; M<=E; E<=stall ? bubble(valid=0, rs=rt=0) : D inputs.
//   - reset=1 at posedge: all records cleared (valid=0, addresses 0). Outputs are combinational
//     from records + D inputs, so in the cycle after reset: stall=0, every fwd_*=00.
//   - Ready: record in stage k is ready iff t<=k. Remaining Tnew = max(t-k,0).
//   - Stall (per operand r in {rs,rt}, skipped if tuse=NONE_T or addr==0):
//       E valid && E.a3==r && (E.t-1) > tuse  -> stall
//       M valid && M.a3==r && (M.t-2) > tuse  -> stall
//     stall = OR over both operands; W never causes stall (value is ready by definition).
//   - Forward select (each consumer): scan younger-to-older stages above the consumer; nearest
//     valid record with matching a3 (addr!=0) wins. If it is ready -> its code; if not ready
//     -> 00 (older matches are stale and MUST NOT be selected). No match -> 00.
//     D scans E,M,W; E scans M,W (using rs/rt stored in E); M scans W (rt stored in M).
//   - Selects are driven regardless of tuse; stall guarantees correctness where they matter.
//   - Stall is single-cycle per evaluation; repeated stalls arise naturally (lw->beq = 2 cycles).
//   - Simultaneous stall and reset: reset wins; no record survives.
//   - No X on outputs for any input, including unknown decoder codes (treated as NONE_T-like).
// TESTING
//   1. add $1 (t=2) in E; D=beq rs=$1 tuse=0 -> stall=1; next cycle add in M -> stall=0, fwd_rs_D=10.
//   2. lw $2 (t=3) in E; D=add rs=$2 tuse=1 -> stall=1 one cycle; then no stall; with add in E,
//      lw in W -> fwd_rs_E=11.
//   3. lw $3 in E (not ready), addiu $3 in M (ready); D=beq rs=$3 -> stall=1, fwd_rs_D=00 (not 10).
//   4. jal (a3=31,t=0) in E; D=jr rs=$31 tuse=0 -> stall=0, fwd_rs_D=01.
//   5. add $0 in E/M/W; D=beq rs=$0 rt=$0 -> stall=0, all fwd_*=00.
//   6. Case 1 setup, assert reset during stall -> next cycle stall=0, all selects 00, records empty.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: D-stage decoder timing codes in (rs/rt/a3, tuse/tnew, regwe), stall and forwarding selects out
interface hazard_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [3:0] tuse_rs_D;
    logic [3:0] tuse_rt_D;
    logic [4:0] a3_D;
    logic [3:0] tnew_D;
    logic       regwe_D;
    logic       stall;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [1:0] fwd_rs_E;
    logic [1:0] fwd_rt_E;
    logic [1:0] fwd_rt_M;
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, regwe_D,
        input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, regwe_D,
        output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage stall and D/E/M forwarding selects from E/M/W shadow records (clk, reset, hazard_if.slave h)
module hazard_unit (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave h
);
    localparam logic [3:0] NONE_T = 4'hF;
    typedef struct packed {
        logic       v;
        logic [4:0] a3;
        logic [3:0] t;
    } rec_t;
    rec_t       e_q, e_d, m_q, m_d, w_q, w_d;
    logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, m_rt_q, m_rt_d;
    function automatic logic known(input logic [3:0] c);
        return c != NONE_T && c <= 4'd3;
    endfunction
    function automatic logic hit(input rec_t x, input logic [4:0] r);
        return x.v && x.a3 == r;
    endfunction
    function automatic logic [1:0] pick(input rec_t x, input logic [1:0] k);
        return x.t <= {2'b00, k} ? k : 2'b00;
    endfunction
    function automatic logic hz(input logic [4:0] r, input logic [3:0] tu, input rec_t e, input rec_t m);
        return known(tu) && r != 5'd0 &&
               ((hit(e, r) && e.t > tu + 4'd1) || (hit(m, r) && m.t > tu + 4'd2));
    endfunction
    // nearest matching record decides; a not-yet-ready one blocks older stale copies
    function automatic logic [1:0] src(input logic [4:0] r, input rec_t a, input rec_t b, input rec_t c);
        return hit(a, r) ? pick(a, 2'd1) : hit(b, r) ? pick(b, 2'd2) : hit(c, r) ? pick(c, 2'd3) : 2'b00;
    endfunction
    always_comb begin
        h.stall    = hz(h.rs_D, h.tuse_rs_D, e_q, m_q) || hz(h.rt_D, h.tuse_rt_D, e_q, m_q);
        h.fwd_rs_D = src(h.rs_D, e_q, m_q, w_q);
        h.fwd_rt_D = src(h.rt_D, e_q, m_q, w_q);
        h.fwd_rs_E = src(e_rs_q, '0, m_q, w_q);
        h.fwd_rt_E = src(e_rt_q, '0, m_q, w_q);
        h.fwd_rt_M = src(m_rt_q, '0, '0, w_q);
        e_d        = h.stall ? '0 : rec_t'{h.regwe_D && h.a3_D != 5'd0 && known(h.tnew_D), h.a3_D, h.tnew_D};
        e_rs_d     = h.stall ? 5'd0 : h.rs_D;
        e_rt_d     = h.stall ? 5'd0 : h.rt_D;
        m_d        = e_q;
        m_rt_d     = e_rt_q;
        w_d        = m_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_rs_q <= '0;
            e_rt_q <= '0;
            m_rt_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
            m_rt_q <= m_rt_d;
        end
    end
endmodule
